// File: rtl/array2d_reader.sv
// array2d_reader: ROWS x COLS register array with a random-access write
// port and a row-major scan-out read port (valid/ready) with done pulse.
//
// Ports:
//   clk, nreset                    clock, async active-low reset
//   wr_en, wr_row, wr_col, wr_data write port (out-of-range rejected)
//   wr_err                         pulse: previous write was out of range
//   start                          begin a scan (sampled in IDLE only)
//   busy                           scan in progress
//   out_valid, out_ready           output beat handshake
//   out_row, out_col, out_data     current beat indices and data
//   done                           pulse: scan complete
module array2d_reader #(
    parameter int DW   = 8,
    parameter int ROWS = 2,
    parameter int COLS = 4,
    parameter int RIW  = 3,
    parameter int CIW  = 3
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           wr_en,
    input  logic [RIW-1:0] wr_row,
    input  logic [CIW-1:0] wr_col,
    input  logic [DW-1:0]  wr_data,
    output logic           wr_err,
    input  logic           start,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [RIW-1:0] out_row,
    output logic [CIW-1:0] out_col,
    output logic [DW-1:0]  out_data,
    output logic           done
);

    localparam logic [RIW-1:0] LAST_ROW = RIW'(ROWS - 1);
    localparam logic [CIW-1:0] LAST_COL = CIW'(COLS - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    state_e         state_q;
    logic [DW-1:0]  mem_q [ROWS][COLS];
    logic           wr_err_q;
    logic           busy_q;
    logic           out_valid_q;
    logic [RIW-1:0] out_row_q;
    logic [CIW-1:0] out_col_q;
    logic [DW-1:0]  out_data_q;
    logic           done_q;

    logic           wr_ok;
    logic           col_wrap;
    logic           last_beat;
    logic [RIW-1:0] nxt_row_d;
    logic [CIW-1:0] nxt_col_d;
    logic [DW-1:0]  rd_data_d;

    assign wr_ok = wr_en && (wr_row <= LAST_ROW) && (wr_col <= LAST_COL);

    // Array storage; writes are accepted in every FSM state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem_q[r][c] <= '0;
                end
            end
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en && !wr_ok;
            if (wr_ok) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        if (wr_row == RIW'(r) && wr_col == CIW'(c)) begin
                            mem_q[r][c] <= wr_data;
                        end
                    end
                end
            end
        end
    end

    // Index of the beat to load next: [0][0] from IDLE, else row-major
    // successor of the beat currently presented.
    always_comb begin
        col_wrap  = (out_col_q == LAST_COL);
        last_beat = col_wrap && (out_row_q == LAST_ROW);
        nxt_row_d = '0;
        nxt_col_d = '0;
        if (state_q == SCAN) begin
            nxt_col_d = col_wrap ? '0 : out_col_q + 1'b1;
            nxt_row_d = col_wrap ? out_row_q + 1'b1 : out_row_q;
        end
    end

    // Read mux reads the pre-edge array, so a same-edge write is not seen.
    always_comb begin
        rd_data_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (nxt_row_d == RIW'(r) && nxt_col_d == CIW'(c)) begin
                    rd_data_d = mem_q[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= SCAN;
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                        out_row_q   <= nxt_row_d;
                        out_col_q   <= nxt_col_d;
                        out_data_q  <= rd_data_d;
                    end
                end
                SCAN: begin
                    if (out_valid_q && out_ready) begin
                        if (last_beat) begin
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            out_row_q  <= nxt_row_d;
                            out_col_q  <= nxt_col_d;
                            out_data_q <= rd_data_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_err    = wr_err_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_array2d_reader.sv
// Testbench for array2d_reader: reference model fills a scoreboard
// queue with expected beats; a negedge monitor pops and compares.
module tb_array2d_reader;

    localparam int DW   = 8;
    localparam int ROWS = 2;
    localparam int COLS = 4;
    localparam int RIW  = 3;
    localparam int CIW  = 3;
    localparam int N    = ROWS * COLS;

    logic           clk;
    logic           nreset;
    logic           wr_en;
    logic [RIW-1:0] wr_row;
    logic [CIW-1:0] wr_col;
    logic [DW-1:0]  wr_data;
    logic           wr_err;
    logic           start;
    logic           busy;
    logic           out_valid;
    logic           out_ready;
    logic [RIW-1:0] out_row;
    logic [CIW-1:0] out_col;
    logic [DW-1:0]  out_data;
    logic           done;

    array2d_reader #(
        .DW(DW), .ROWS(ROWS), .COLS(COLS), .RIW(RIW), .CIW(CIW)
    ) dut (
        .clk(clk), .nreset(nreset),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .wr_err(wr_err),
        .start(start), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col), .out_data(out_data),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [RIW-1:0] r;
        logic [CIW-1:0] c;
        logic [DW-1:0]  d;
    } beat_t;

    beat_t         q[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [DW-1:0] ref_mem [N];
    bit            m_busy;
    int            m_idx;
    bit            exp_done;
    bit            exp_err;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int idx);
        beat_t b;
        b.r = RIW'(idx / COLS);
        b.c = CIW'(idx % COLS);
        b.d = ref_mem[idx];
        return b;
    endfunction

    // Reference model: scan is a linear index 0..N-1 over a flat array.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) ref_mem[i] = '0;
            m_busy   = 0;
            m_idx    = 0;
            exp_done = 0;
            exp_err  = 0;
            q.delete();
        end else begin
            exp_done = 0;
            if (m_busy) begin
                if (out_ready) begin
                    if (m_idx == N - 1) begin
                        m_busy   = 0;
                        exp_done = 1;
                    end else begin
                        m_idx++;
                        q.push_back(mk(m_idx));
                    end
                end
            end else if (start) begin
                m_busy = 1;
                m_idx  = 0;
                q.push_back(mk(0));
            end
            exp_err = wr_en && !(int'(wr_row) < ROWS && int'(wr_col) < COLS);
            if (wr_en && int'(wr_row) < ROWS && int'(wr_col) < COLS)
                ref_mem[int'(wr_row) * COLS + int'(wr_col)] = wr_data;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!nreset) begin
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", wr_err, 0);
            chk("rst_data", {out_row, out_col, out_data}, 0);
        end else begin
            chk("valid", out_valid, m_busy);
            chk("busy", busy, m_busy);
            chk("done", done, exp_done);
            chk("wr_err", wr_err, exp_err);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    chk("beat_row", out_row, q[0].r);
                    chk("beat_col", out_col, q[0].c);
                    chk("beat_data", out_data, q[0].d);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input int c, input int d);
        wr_en   = 1'b1;
        wr_row  = RIW'(r);
        wr_col  = CIW'(c);
        wr_data = DW'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start_scan();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: ready high; 1: 1,0,0,1,0,1 pattern; 2: random traffic
    task automatic run_scan(input int mode);
        int k;
        k = 0;
        while (m_busy && k < 200) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (k % 6 == 0) || (k % 6 == 3) || (k % 6 == 5);
                default: begin
                    out_ready = 1'($urandom_range(0, 1));
                    start     = 1'($urandom_range(0, 3) == 0);
                    wr_en     = 1'($urandom_range(0, 1));
                    wr_row    = RIW'($urandom_range(0, 3));
                    wr_col    = CIW'($urandom_range(0, 5));
                    wr_data   = DW'($urandom);
                end
            endcase
            tick();
            k++;
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (m_busy) chk("scan_timeout", 1, 0);
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        nreset    = 1'b0;
        wr_en     = 1'b0;
        wr_row    = '0;
        wr_col    = '0;
        wr_data   = '0;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        nreset = 1'b1;
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_row", out_row, 0);
        chk("idle_col", out_col, 0);
        chk("idle_data", out_data, 0);

        // scan of a freshly reset array
        start_scan();
        run_scan(0);

        // fill and stream
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wr(r, c, 8'hF0 + 4 * r + c);
        start_scan();
        run_scan(0);

        // out-of-range writes
        wr(3, 0, 8'hC1);
        wr(1, 4, 8'hC2);
        wr(4, 2, 8'hC3);
        tick();
        start_scan();
        run_scan(0);

        // backpressure
        start_scan();
        run_scan(1);

        // write during scan while beat [0][2] is pending
        start_scan();
        tick();
        tick();
        out_ready = 1'b0;
        wr(0, 2, 8'hAA);
        wr(1, 1, 8'hBB);
        tick();
        chk("hold_02_data", out_data, 8'hF2);
        chk("hold_02_col", out_col, 2);
        run_scan(0);

        // reset mid-scan and restart with start held while busy
        start_scan();
        tick();
        tick();
        tick();
        nreset = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_done", done, 0);
        chk("midrst_data", out_data, 0);
        tick();
        tick();
        nreset = 1'b1;
        start  = 1'b1;
        tick();
        tick();
        tick();
        start = 1'b0;
        run_scan(0);

        // randomized traffic with back-to-back restarts
        for (int it = 0; it < 12; it++) begin
            for (int w = 0; w < 4; w++)
                wr($urandom_range(0, 2), $urandom_range(0, 4), $urandom);
            start_scan();
            run_scan(2);
        end

        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
